// File: rtl/xnor3_parity_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one registered XNOR3 fold stage between NREQ
// requesters; returns each job's even parity tagged with the requester index.
module xnor3_parity_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       din,
  input  logic [NREQ-1:0]         dvalid,
  input  logic [NREQ-1:0]         dlast,
  output logic [NREQ-1:0]         gnt,
  output logic                    dready,
  output logic                    busy,
  output logic                    done,
  output logic                    par,
  output logic [$clog2(NREQ)-1:0] par_id
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(W / 2 + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FOLD, S_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   pick;
  logic            found;
  logic [W-1:0]    sr;
  logic [W-1:0]    word_g;
  logic            dvalid_g;
  logic            dlast_g;
  logic            last_word;
  logic            acc;
  logic            acc_nx;
  logic            inv;
  logic [CW-1:0]   cnt;

  // First requesting index at or above ptr, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[IW'((32'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        pick  = IW'((32'(ptr) + k) % NREQ);
      end
    end
  end

  // Data, valid and last of the granted requester only.
  always_comb begin
    word_g   = '0;
    dvalid_g = 1'b0;
    dlast_g  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        word_g   = din[i*W +: W];
        dvalid_g = dvalid[i];
        dlast_g  = dlast[i];
      end
    end
  end

  assign acc_nx = ~(acc ^ sr[0] ^ sr[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      sr        <= '0;
      last_word <= 1'b0;
      acc       <= 1'b0;
      inv       <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      dready    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      par       <= 1'b0;
      par_id    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            gidx   <= pick;
            gnt    <= NREQ'(1) << pick;
            acc    <= 1'b0;
            inv    <= 1'b0;
            busy   <= 1'b1;
            dready <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (dvalid_g) begin
            sr        <= word_g;
            last_word <= dlast_g;
            cnt       <= CW'(W / 2);
            dready    <= 1'b0;
            state     <= S_FOLD;
          end
        end
        S_FOLD: begin
          acc <= acc_nx;
          sr  <= sr >> 2;
          inv <= ~inv;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (last_word) begin
              // Odd XNOR count leaves acc inverted; inv tracks that parity.
              done   <= 1'b1;
              par    <= acc_nx ^ ~inv;
              par_id <= gidx;
              state  <= S_DONE;
            end else begin
              dready <= 1'b1;
              state  <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
